// File: rtl/miniscope_seq_if.sv
// Miniscope recorder bus: write-side inputs, readout stream and parity status.
interface miniscope_seq_if #(
    parameter int NCH   = 2,
    parameter int WIDTH = 8,
    parameter int ADRB  = 11,
    parameter int ECNTB = 8
);
    logic                   wr_en;
    logic [NCH*WIDTH-1:0]   wr_data;
    logic                   tbins_test;
    logic                   l1a;
    logic [ADRB-1:0]        offset;
    logic [ADRB-1:0]        tbins;
    logic                   parity_clr;
    logic [ADRB-1:0]        wadr;
    logic                   rd_busy;
    logic                   rd_valid;
    logic [NCH*WIDTH-1:0]   rd_data;
    logic [ADRB-1:0]        rd_tbin;
    logic                   rd_done;
    logic [NCH-1:0]         parity_err;
    logic [ECNTB-1:0]       parity_err_cnt;

    modport master (
        output wr_en, wr_data, tbins_test, l1a, offset, tbins, parity_clr,
        input  wadr, rd_busy, rd_valid, rd_data, rd_tbin, rd_done,
        input  parity_err, parity_err_cnt
    );

    modport slave (
        input  wr_en, wr_data, tbins_test, l1a, offset, tbins, parity_clr,
        output wadr, rd_busy, rd_valid, rd_data, rd_tbin, rd_done,
        output parity_err, parity_err_cnt
    );
endinterface

// File: rtl/miniscope_seq.sv
// Multi-channel miniscope: circular bx recorder with L1A look-back readout
// and per-channel parity checking on the read path.
module miniscope_seq #(
    parameter int NCH   = 2,
    parameter int WIDTH = 8,
    parameter int ADRB  = 11,
    parameter int ECNTB = 8
) (
    input logic           clock,
    input logic           reset_n,
    miniscope_seq_if.slave bus
);
    localparam int DW    = NCH * WIDTH;
    localparam int RW    = DW + NCH;
    localparam int DEPTH = 2 ** ADRB;

    typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

    state_t            state, state_nx;
    logic [ADRB-1:0]   wadr;
    logic [ADRB-1:0]   radr;
    logic [ADRB-1:0]   count;
    logic [ADRB-1:0]   tbin_ctr;
    logic [ADRB-1:0]   rd_tbin;
    logic              test_ff;
    logic              rd_valid;
    logic [RW-1:0]     ram [DEPTH];
    logic [RW-1:0]     wr_word;
    logic [RW-1:0]     rd_q;
    logic [NCH-1:0]    chk_err;
    logic [NCH-1:0]    par_err;
    logic [ECNTB-1:0]  err_cnt;

    // Stored word layout: {parity[NCH-1:0], ch[NCH-1], ..., ch[0]}
    always_comb begin
        wr_word = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_word[i*WIDTH +: WIDTH] = test_ff
                ? WIDTH'(32'(wadr) + 32'(i))
                : bus.wr_data[i*WIDTH +: WIDTH];
            wr_word[DW+i] = ~(^wr_word[i*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clock) begin
        if (bus.wr_en)
            ram[wadr] <= wr_word;
    end

    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.l1a)
                    state_nx = (bus.tbins == '0) ? DONE : READ;
            end
            READ: begin
                if (count == ADRB'(1))
                    state_nx = FLUSH;
            end
            FLUSH: state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        chk_err = '0;
        for (int i = 0; i < NCH; i++)
            chk_err[i] = rd_valid &&
                (rd_q[DW+i] != ~(^rd_q[i*WIDTH +: WIDTH]));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wadr     <= '0;
            test_ff  <= 1'b0;
            radr     <= '0;
            count    <= '0;
            tbin_ctr <= '0;
            rd_tbin  <= '0;
            rd_q     <= '0;
            rd_valid <= 1'b0;
            par_err  <= '0;
            err_cnt  <= '0;
        end else begin
            test_ff  <= bus.tbins_test;
            rd_valid <= (state == READ);
            if (bus.wr_en)
                wadr <= wadr + ADRB'(1);
            if (state == IDLE && bus.l1a) begin
                radr     <= wadr - bus.offset;
                count    <= bus.tbins;
                tbin_ctr <= '0;
            end else if (state == READ) begin
                rd_q     <= ram[radr];
                rd_tbin  <= tbin_ctr;
                radr     <= radr + ADRB'(1);
                count    <= count - ADRB'(1);
                tbin_ctr <= tbin_ctr + ADRB'(1);
            end
            // A clear in the same cycle as a fresh error drops that error.
            if (bus.parity_clr) begin
                par_err <= '0;
                err_cnt <= '0;
            end else begin
                par_err <= par_err | chk_err;
                if ((|chk_err) && (err_cnt != '1))
                    err_cnt <= err_cnt + ECNTB'(1);
            end
        end
    end

    assign bus.wadr           = wadr;
    assign bus.rd_busy        = (state == READ) || (state == FLUSH);
    assign bus.rd_valid       = rd_valid;
    assign bus.rd_data        = rd_q[DW-1:0];
    assign bus.rd_tbin        = rd_tbin;
    assign bus.rd_done        = (state == DONE);
    assign bus.parity_err     = par_err;
    assign bus.parity_err_cnt = err_cnt;
endmodule
